// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared state encoding and default sizing for the truth-table sequencer
package truth_table_sequencer_pkg;

    localparam int DEF_N_IN   = 3;
    localparam int DEF_N_OUT  = 2;
    localparam int DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// rtl/truth_table_sequencer_if.sv - control, gate-block and result signals of the truth-table sequencer
interface truth_table_sequencer_if
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT
);
    logic                        start;
    logic                        abort;
    logic [N_OUT-1:0]            res_in;
    logic [N_OUT*(2**N_IN)-1:0]  exp_table;
    logic [N_IN-1:0]             vec_out;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [N_IN:0]               err_cnt;
    logic                        fail_valid;
    logic [N_IN-1:0]             first_fail;
    logic [N_OUT*(2**N_IN)-1:0]  table_out;

    modport master (
        output start, abort, res_in, exp_table,
        input  vec_out, busy, done, pass, err_cnt, fail_valid, first_fail, table_out
    );

    modport slave (
        input  start, abort, res_in, exp_table,
        output vec_out, busy, done, pass, err_cnt, fail_valid, first_fail, table_out
    );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// rtl/truth_table_sequencer_settle_timer.sv - 8-bit settle counter, flags the last hold cycle of a vector
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors through a gate block and checks the captured truth table
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sequencer_if.slave bus
);
    localparam int              TW       = N_OUT * (2 ** N_IN);
    localparam logic [N_IN-1:0] VEC_ONE  = 1;
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN:0]   ERR_ONE  = 1;

    state_t            state, state_next;
    logic [N_IN-1:0]   vec;
    logic [TW-1:0]     table_q;
    logic [N_IN:0]     err_cnt;
    logic              fail_valid;
    logic [N_IN-1:0]   first_fail;
    logic              pass;
    logic              expired;
    logic              last_vec;
    logic              mismatch;

    // Counter sits at zero outside SETTLE, so every vector starts a fresh hold.
    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state != ST_SETTLE),
        .expired (expired)
    );

    assign last_vec = (vec == VEC_LAST);
    assign mismatch = (bus.res_in != bus.exp_table[int'(vec)*N_OUT +: N_OUT]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bus.start) state_next = ST_SETTLE;
            ST_SETTLE:  if (bus.abort) state_next = ST_IDLE;
                        else if (expired) state_next = ST_CAPTURE;
            ST_CAPTURE: if (bus.abort) state_next = ST_IDLE;
                        else if (last_vec) state_next = ST_DONE;
                        else state_next = ST_SETTLE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec        <= '0;
            table_q    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        vec        <= '0;
                        table_q    <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) vec <= '0;
                end
                ST_CAPTURE: begin
                    // Abort wins over the capture write; partial results stay visible.
                    if (bus.abort) begin
                        vec <= '0;
                    end else begin
                        table_q[int'(vec)*N_OUT +: N_OUT] <= bus.res_in;
                        if (mismatch) begin
                            err_cnt <= err_cnt + ERR_ONE;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= vec;
                            end
                        end
                        if (!last_vec) vec <= vec + VEC_ONE;
                    end
                end
                ST_DONE: begin
                    pass <= (err_cnt == '0);
                    vec  <= '0;
                end
                default: vec <= '0;
            endcase
        end
    end

    assign bus.vec_out    = vec;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = pass;
    assign bus.err_cnt    = err_cnt;
    assign bus.fail_valid = fail_valid;
    assign bus.first_fail = first_fail;
    assign bus.table_out  = table_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed bench with a cycle-count model for SETTLE=1 and SETTLE=4 instances
module tb_truth_table_sequencer;
    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int N_VEC = 8;
    localparam int TW    = 16;
    // Gate {^v, &v} gives entries 0,2,2,0,2,0,0,3 for v = 0..7.
    localparam logic [TW-1:0] GOLD  = 16'hC228;
    localparam logic [TW-1:0] FAULT = 16'hC228 ^ 16'h00C0 ^ 16'h0C00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [TW-1:0] exp_tab;
    logic          start_v [2];
    logic          abort_v [2];
    bit            chk_en = 1'b0;
    int            n_vec = 0;
    int            n_bad = 0;
    int            c;

    truth_table_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_a ();
    truth_table_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_b ();

    function automatic logic [1:0] gate(input logic [2:0] v);
        return {^v, &v};
    endfunction

    assign bus_a.start     = start_v[0];
    assign bus_a.abort     = abort_v[0];
    assign bus_a.exp_table = exp_tab;
    assign bus_a.res_in    = gate(bus_a.vec_out);
    assign bus_b.start     = start_v[1];
    assign bus_b.abort     = abort_v[1];
    assign bus_b.exp_table = exp_tab;
    assign bus_b.res_in    = gate(bus_b.vec_out);

    truth_table_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    truth_table_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Model: m_t is the cycle number within the sweep (1 = first hold cycle).
    bit            m_run  [2];
    int            m_t    [2];
    logic [TW-1:0] m_tab  [2];
    int            m_err  [2];
    bit            m_fv   [2];
    int            m_ff   [2];
    bit            m_pass [2];

    function automatic int s_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int last_t(input int i);
        return N_VEC * (s_of(i) + 1) + 1;
    endfunction

    always @(posedge clk) begin
        int k;
        logic [1:0] r, e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_t[i] = 0; m_tab[i] = '0; m_err[i] = 0;
                m_fv[i] = 0; m_ff[i] = 0; m_pass[i] = 0;
            end else if (!m_run[i]) begin
                if (start_v[i]) begin
                    m_run[i] = 1; m_t[i] = 1; m_tab[i] = '0; m_err[i] = 0;
                    m_fv[i] = 0; m_ff[i] = 0; m_pass[i] = 0;
                end
            end else if (m_t[i] == last_t(i)) begin
                m_pass[i] = (m_err[i] == 0);
                m_run[i]  = 0;
            end else if (abort_v[i]) begin
                m_run[i] = 0;
            end else begin
                if (m_t[i] % (s_of(i) + 1) == 0) begin
                    k = m_t[i] / (s_of(i) + 1) - 1;
                    r = gate(3'(k));
                    e = exp_tab[2*k +: 2];
                    m_tab[i][2*k +: 2] = r;
                    if (r != e) begin
                        m_err[i]++;
                        if (!m_fv[i]) begin
                            m_fv[i] = 1;
                            m_ff[i] = k;
                        end
                    end
                end
                m_t[i]++;
            end
        end
    end

    function automatic logic [63:0] pack_out(input logic busy, input logic done,
            input logic [2:0] vec, input logic pass, input logic [3:0] err,
            input logic fv, input logic [2:0] ff, input logic [15:0] tab);
        return 64'({busy, done, vec, pass, err, fv, ff, tab});
    endfunction

    function automatic logic [63:0] model_out(input int i);
        int v;
        v = m_run[i] ? (m_t[i] - 1) / (s_of(i) + 1) : 0;
        if (v > N_VEC - 1) v = N_VEC - 1;
        return pack_out(m_run[i], m_run[i] && (m_t[i] == last_t(i)), 3'(v), m_pass[i],
                        4'(m_err[i]), m_fv[i], 3'(m_ff[i]), m_tab[i]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs_a", pack_out(bus_a.busy, bus_a.done, bus_a.vec_out, bus_a.pass,
                bus_a.err_cnt, bus_a.fail_valid, bus_a.first_fail, bus_a.table_out), model_out(0));
            chk("outputs_b", pack_out(bus_b.busy, bus_b.done, bus_b.vec_out, bus_b.pass,
                bus_b.err_cnt, bus_b.fail_valid, bus_b.first_fail, bus_b.table_out), model_out(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic a, input logic b);
        start_v[0] = a;
        start_v[1] = b;
        step();
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
    endtask

    task automatic run_to_done(input int i, inout int cyc);
        while (!((i == 0) ? bus_a.done : bus_b.done) && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = '{1'b0, 1'b0};
        abort_v = '{1'b0, 1'b0};
        exp_tab = GOLD;
        repeat (3) step();
        chk_en = 1'b1;
        chk("reset_table", 64'(bus_a.table_out), 64'(0));
        chk("reset_flags", 64'({bus_a.busy, bus_a.done, bus_a.pass, bus_a.vec_out}), 64'(0));
        rst_n = 1'b1;
        step();

        // Golden sweep on both instances.
        pulse_start(1'b1, 1'b1);
        c = 1;
        run_to_done(0, c);
        chk("gold_done_cycle", 64'(c), 64'(17));
        run_to_done(1, c);
        chk("settle4_done_cycle", 64'(c), 64'(41));
        step();
        chk("gold_table", 64'(bus_a.table_out), 64'(GOLD));
        chk("gold_pass_err", 64'({bus_a.pass, bus_a.err_cnt}), 64'({1'b1, 4'd0}));
        chk("settle4_table", 64'(bus_b.table_out), 64'(GOLD));

        // Entries 3 and 5 flipped in the expectation.
        exp_tab = FAULT;
        pulse_start(1'b1, 1'b0);
        c = 1;
        run_to_done(0, c);
        chk("fault_done_cycle", 64'(c), 64'(17));
        step();
        chk("fault_result", 64'({bus_a.err_cnt, bus_a.first_fail, bus_a.fail_valid, bus_a.pass}),
            64'({4'd2, 3'd3, 1'b1, 1'b0}));

        // Abort in cycle 9.
        exp_tab = GOLD;
        pulse_start(1'b1, 1'b1);
        c = 1;
        while (c < 9) begin step(); c++; end
        abort_v = '{1'b1, 1'b1};
        step();
        abort_v = '{1'b0, 1'b0};
        chk("abort_busy", 64'({bus_a.busy, bus_b.busy}), 64'(0));
        chk("abort_table", 64'(bus_a.table_out), 64'(16'h0028));
        chk("abort_pass", 64'({bus_a.pass, bus_a.err_cnt}), 64'(0));
        chk("abort_table_b", 64'(bus_b.table_out), 64'(0));
        repeat (4) step();

        // Start while busy is ignored; restart in the cycle after DONE.
        exp_tab = FAULT;
        pulse_start(1'b1, 1'b0);
        c = 1;
        while (c < 5) begin step(); c++; end
        start_v[0] = 1'b1;
        step();
        c++;
        start_v[0] = 1'b0;
        run_to_done(0, c);
        chk("busy_start_done_cycle", 64'(c), 64'(17));
        step();
        chk("first_sweep_err", 64'(bus_a.err_cnt), 64'(2));
        exp_tab = GOLD;
        pulse_start(1'b1, 1'b0);
        chk("restart_cleared", 64'({bus_a.err_cnt, bus_a.fail_valid, bus_a.table_out}), 64'(0));
        c = 1;
        run_to_done(0, c);
        chk("restart_done_cycle", 64'(c), 64'(17));
        step();
        chk("restart_pass", 64'({bus_a.pass, bus_a.table_out}), 64'({1'b1, GOLD}));

        // Reset asserted in cycle 6 of a sweep.
        pulse_start(1'b1, 1'b1);
        c = 1;
        while (c < 6) begin step(); c++; end
        rst_n = 1'b0;
        step();
        chk("midreset_outputs", pack_out(bus_a.busy, bus_a.done, bus_a.vec_out, bus_a.pass,
            bus_a.err_cnt, bus_a.fail_valid, bus_a.first_fail, bus_a.table_out), 64'(0));
        rst_n = 1'b1;
        pulse_start(1'b1, 1'b0);
        c = 1;
        run_to_done(0, c);
        chk("post_reset_done_cycle", 64'(c), 64'(17));
        step();
        chk("post_reset_result", 64'({bus_a.pass, bus_a.table_out}), 64'({1'b1, GOLD}));

        repeat (2) step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
